// File: rtl/rand_sample_buffer_pkg.sv
// Shared definitions for the LFSR sample buffer.
//   DW_DEF   : default sample width (matches the generator's RandNum)
//   SAMPLE_W : width constant for sample-typed signals
//   hstate_t : health FSM states
package rand_pkg;
  localparam int DW_DEF   = 8;
  localparam int SAMPLE_W = DW_DEF;

  typedef enum logic {
    RUN = 1'b0,
    REQ = 1'b1
  } hstate_t;
endpackage

// File: rtl/rand_sample_buffer_if.sv
// Sample-in / sample-out handshake bundle.
//   Gen_done, RandNum : sample strobe and data from the LFSR generator
//   out_valid/out_data/out_ready : FWFT valid/ready consumer port
//   slave  : buffer side
//   master : generator/consumer side
interface rand_sample_buffer_if #(parameter int DW = 8);
  logic          Gen_done;
  logic [DW-1:0] RandNum;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport slave  (input  Gen_done, RandNum, out_ready,
                  output out_valid, out_data);
  modport master (output Gen_done, RandNum, out_ready,
                  input  out_valid, out_data);
endinterface

// File: rtl/rand_sample_buffer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (discards contents)
//   push/wdata : write request; ignored when full unless popping same cycle
//   pop        : read request; ignored when empty
//   rdata      : head entry, 0 while empty
//   full/empty/level : occupancy 0..DEPTH
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [LW-1:0]            cnt;
  logic                     wr_en, rd_en;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  // Popping frees a slot in the same cycle, so a full FIFO may still write.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  // Gate the head with empty so reset/drained output reads as zero.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/rand_sample_buffer.sv
// LFSR sample buffer with health monitor.
//   clk, rst_n  : clock, async active-low reset
//   bus         : Gen_done/RandNum in, FWFT out_valid/out_data/out_ready out
//   level       : FIFO occupancy 0..DEPTH
//   drop_cnt    : saturating count of samples lost to a full FIFO
//   stuck       : sticky flag, zero sample or STUCK_N identical samples
//   reseed_req  : held until reseed_ack
//   reseed_ack  : seed controller acknowledge
//   clr_stats   : clears drop_cnt and stuck
module rand_sample_buffer
  import rand_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = 8,
  parameter int STUCK_N = 4,
  parameter int DROP_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rand_sample_buffer_if.slave    bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   stuck,
  output logic                   reseed_req,
  input  logic                   reseed_ack,
  input  logic                   clr_stats
);
  localparam int RW = $clog2(STUCK_N) + 1;

  hstate_t       state, state_n;
  logic [RW-1:0] rep_cnt;
  logic [DW-1:0] last;
  logic          take, stuck_evt, clr_rep, bump_rep, upd_last;
  logic          full, empty, pop, drop;

  // Health FSM: classify each strobe while running.
  always_comb begin
    state_n   = state;
    take      = 1'b0;
    stuck_evt = 1'b0;
    clr_rep   = 1'b0;
    bump_rep  = 1'b0;
    upd_last  = 1'b0;
    if (state == RUN) begin
      if (bus.Gen_done) begin
        if (bus.RandNum == '0) begin
          stuck_evt = 1'b1;
          state_n   = REQ;
        end else begin
          take = 1'b1;
          if (bus.RandNum == last) begin
            bump_rep = 1'b1;
            // This repeat makes STUCK_N identical samples in a row.
            if (rep_cnt == RW'(STUCK_N - 2)) begin
              stuck_evt = 1'b1;
              state_n   = REQ;
            end
          end else begin
            upd_last = 1'b1;
          end
        end
      end
    end else begin
      if (reseed_ack) begin
        state_n = RUN;
        clr_rep = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      rep_cnt    <= '0;
      last       <= '0;
      reseed_req <= 1'b0;
    end else begin
      state      <= state_n;
      reseed_req <= (state_n == REQ);
      if (clr_rep) begin
        rep_cnt <= '0;
        last    <= '0;
      end else if (upd_last) begin
        rep_cnt <= '0;
        last    <= bus.RandNum;
      end else if (bump_rep) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign pop  = bus.out_valid & bus.out_ready;
  assign drop = take & full & ~pop;
  assign bus.out_valid = ~empty;

  // clr_stats takes priority over a coincident drop or stuck event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      stuck    <= 1'b0;
    end else if (clr_stats) begin
      drop_cnt <= '0;
      stuck    <= 1'b0;
    end else begin
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (stuck_evt) stuck <= 1'b1;
    end
  end

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (take),
    .wdata (bus.RandNum),
    .pop   (pop),
    .rdata (bus.out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_rand_sample_buffer.sv
// Directed bench for rand_sample_buffer (DW=8, DEPTH=8, STUCK_N=4, DROP_W=8).
module tb_rand_sample_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] level;
  logic [7:0] drop_cnt;
  logic       stuck, reseed_req, reseed_ack, clr_stats;
  int checks = 0;
  int errors = 0;

  rand_sample_buffer_if #(.DW(8)) bus ();

  rand_sample_buffer #(.DW(8), .DEPTH(8), .STUCK_N(4), .DROP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .level      (level),
    .drop_cnt   (drop_cnt),
    .stuck      (stuck),
    .reseed_req (reseed_req),
    .reseed_ack (reseed_ack),
    .clr_stats  (clr_stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       gen;
    logic [7:0] d;
    logic       rdy, ack, clr;
    logic       vld;
    logic [7:0] od;
    logic [3:0] lvl;
    logic [7:0] drp;
    logic       stk, req;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(logic gen, logic [7:0] d, logic rdy, logic ack, logic clr,
                              logic vld, logic [7:0] od, logic [3:0] lvl, logic [7:0] drp,
                              logic stk, logic req);
    vec_t v;
    v.gen = gen; v.d = d; v.rdy = rdy; v.ack = ack; v.clr = clr;
    v.vld = vld; v.od = od; v.lvl = lvl; v.drp = drp; v.stk = stk; v.req = req;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic gen, input logic [7:0] d, input logic rdy,
                       input logic ack, input logic clr);
    bus.Gen_done  = gen;
    bus.RandNum   = d;
    bus.out_ready = rdy;
    reseed_ack    = ack;
    clr_stats     = clr;
  endtask

  task automatic chk_all(input string nm, input int idx, input logic vld, input logic [7:0] od,
                         input logic [3:0] lvl, input logic [7:0] drp, input logic stk,
                         input logic req);
    chk({nm, ".valid"}, idx, 32'(bus.out_valid), 32'(vld));
    chk({nm, ".data"},  idx, 32'(bus.out_data),  32'(od));
    chk({nm, ".level"}, idx, 32'(level),         32'(lvl));
    chk({nm, ".drop"},  idx, 32'(drop_cnt),      32'(drp));
    chk({nm, ".stuck"}, idx, 32'(stuck),         32'(stk));
    chk({nm, ".req"},   idx, 32'(reseed_req),    32'(req));
  endtask

  initial begin
    // in: gen d rdy ack clr | exp after edge: vld od lvl drp stk req
    // ordered stream, one-cycle FWFT latency
    vt[0]  = mk(1, 8'h35, 1, 0, 0,  1, 8'h35, 1, 0, 0, 0);
    vt[1]  = mk(1, 8'h6A, 1, 0, 0,  1, 8'h6A, 1, 0, 0, 0);
    vt[2]  = mk(1, 8'hD5, 1, 0, 0,  1, 8'hD5, 1, 0, 0, 0);
    vt[3]  = mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0);
    // zero sample: not pushed, stuck, request; samples ignored in REQ
    vt[4]  = mk(1, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0, 1, 1);
    vt[5]  = mk(1, 8'h11, 1, 0, 0,  0, 8'h00, 0, 0, 1, 1);
    vt[6]  = mk(0, 8'h00, 1, 1, 0,  0, 8'h00, 0, 0, 1, 0);
    vt[7]  = mk(0, 8'h00, 1, 0, 1,  0, 8'h00, 0, 0, 0, 0);
    // four identical samples: all pushed, then REQ
    vt[8]  = mk(1, 8'hA5, 0, 0, 0,  1, 8'hA5, 1, 0, 0, 0);
    vt[9]  = mk(1, 8'hA5, 0, 0, 0,  1, 8'hA5, 2, 0, 0, 0);
    vt[10] = mk(1, 8'hA5, 0, 0, 0,  1, 8'hA5, 3, 0, 0, 0);
    vt[11] = mk(1, 8'hA5, 0, 0, 0,  1, 8'hA5, 4, 0, 1, 1);
    vt[12] = mk(1, 8'hA5, 0, 0, 0,  1, 8'hA5, 4, 0, 1, 1);
    vt[13] = mk(0, 8'h00, 0, 1, 0,  1, 8'hA5, 4, 0, 1, 0);
    vt[14] = mk(1, 8'h5A, 0, 0, 0,  1, 8'hA5, 5, 0, 1, 0);
    vt[15] = mk(0, 8'h00, 0, 0, 1,  1, 8'hA5, 5, 0, 0, 0);
    vt[16] = mk(0, 8'h00, 1, 0, 0,  1, 8'hA5, 4, 0, 0, 0);
    vt[17] = mk(0, 8'h00, 1, 0, 0,  1, 8'hA5, 3, 0, 0, 0);
    vt[18] = mk(0, 8'h00, 1, 0, 0,  1, 8'hA5, 2, 0, 0, 0);
    vt[19] = mk(0, 8'h00, 1, 0, 0,  1, 8'h5A, 1, 0, 0, 0);
    vt[20] = mk(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].gen, vt[i].d, vt[i].rdy, vt[i].ack, vt[i].clr);
      step();
      chk_all("vec", i, vt[i].vld, vt[i].od, vt[i].lvl, vt[i].drp, vt[i].stk, vt[i].req);
    end

    // overflow: 10 samples into 8 entries
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'(i + 1), 0, 0, 0);
      step();
    end
    drive(0, 8'h00, 0, 0, 0);
    chk("ovf.level", 0, 32'(level), 32'd8);
    chk("ovf.drop",  0, 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("drain.data", i, 32'(bus.out_data), 32'(i + 1));
      drive(0, 8'h00, 1, 0, 0);
      step();
    end
    chk("drain.valid", 0, 32'(bus.out_valid), 32'd0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'(8'h10 + i), 0, 0, 0);
      step();
    end
    chk("full.level", 0, 32'(level), 32'd8);
    drive(1, 8'h18, 1, 0, 0);
    step();
    chk("pp.level", 0, 32'(level), 32'd8);
    chk("pp.drop",  0, 32'(drop_cnt), 32'd2);
    chk("pp.data",  0, 32'(bus.out_data), 32'h11);

    // drop counter saturation
    for (int i = 0; i < 253; i++) begin
      drive(1, (i % 2 == 0) ? 8'h21 : 8'h22, 0, 0, 0);
      step();
    end
    chk("sat.drop", 0, 32'(drop_cnt), 32'hFF);
    for (int i = 0; i < 3; i++) begin
      drive(1, (i % 2 == 0) ? 8'h22 : 8'h21, 0, 0, 0);
      step();
    end
    chk("sat.hold", 0, 32'(drop_cnt), 32'hFF);
    chk("sat.level", 0, 32'(level), 32'd8);
    // clear beats a coincident drop
    drive(1, 8'h21, 0, 0, 1);
    step();
    chk("clr.drop", 0, 32'(drop_cnt), 32'd0);
    drive(0, 8'h00, 0, 0, 0);

    // async reset mid-stream
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'h40 + i), 0, 0, 0);
      step();
    end
    drive(1, 8'h00, 0, 0, 0);
    step();
    drive(0, 8'h00, 0, 0, 0);
    chk("pre.level", 0, 32'(level), 32'd5);
    chk("pre.stuck", 0, 32'(stuck), 32'd1);
    chk("pre.req",   0, 32'(reseed_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async", 0, 0, 8'h00, 0, 0, 0, 0);
    #3;
    rst_n = 1'b1;
    step();
    drive(1, 8'h44, 0, 0, 0);
    step();
    drive(0, 8'h00, 0, 0, 0);
    chk_all("resume", 0, 1, 8'h44, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
